// File: rtl/icache_refill_unit.sv
// Instruction-cache refill engine: takes one held miss from the fetch unit,
// issues a line-aligned memory read, assembles the returned beats into a
// cacheline and strobes the cache-update port for a single cycle.
module icache_refill_unit #(
  parameter int unsigned offsetSize        = 5,
  parameter int unsigned indexSize         = 8,
  parameter int unsigned tagSize           = 64 - (offsetSize + indexSize),
  parameter int unsigned cachelineSizeBits = (2 ** offsetSize) * 8,
  parameter int unsigned memBusWidth       = 64
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         isCacheMiss_i,
  input  logic [tagSize-1:0]           missTag_i,
  input  logic [indexSize-1:0]         missIndex_i,
  input  logic [offsetSize-1:0]        missOffset_i,
  output logic                         memReqValid_o,
  input  logic                         memReqReady_i,
  output logic [63:0]                  memReqAddr_o,
  input  logic                         memRespValid_i,
  input  logic [memBusWidth-1:0]       memRespData_i,
  output logic [tagSize-1:0]           newTag_o,
  output logic [indexSize-1:0]         newIndex_o,
  output logic [offsetSize-1:0]        newOffset_o,
  output logic [cachelineSizeBits-1:0] newCacheline_o,
  output logic                         cacheUpdateEnable_o,
  output logic                         busy_o
);

  localparam int unsigned beatsPerLine = cachelineSizeBits / memBusWidth;
  localparam int unsigned cntW         = $clog2(beatsPerLine);
  localparam logic [cntW-1:0] lastBeat = cntW'(beatsPerLine - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    WRITE,
    CLEAR
  } state_t;

  state_t          state;
  logic [cntW-1:0] beat_cnt;

  // Refill sequencer: capture miss, request line, gather beats, strobe update, cool down.
  // The captured tag/index/offset registers double as the update-port outputs,
  // so they hold after the strobe until the next capture.
  // Beat k lands in the k-th 64-bit slice counted from the MSB end, so the
  // finished line reads {beat0, beat1, ..., beatN-1}.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state               <= IDLE;
      beat_cnt            <= '0;
      memReqValid_o       <= 1'b0;
      memReqAddr_o        <= '0;
      newTag_o            <= '0;
      newIndex_o          <= '0;
      newOffset_o         <= '0;
      newCacheline_o      <= '0;
      cacheUpdateEnable_o <= 1'b0;
      busy_o              <= 1'b0;
    end else begin
      cacheUpdateEnable_o <= 1'b0;
      case (state)
        IDLE: begin
          if (isCacheMiss_i) begin
            newTag_o      <= missTag_i;
            newIndex_o    <= missIndex_i;
            newOffset_o   <= missOffset_i;
            memReqAddr_o  <= {missTag_i, missIndex_i, {offsetSize{1'b0}}};
            memReqValid_o <= 1'b1;
            busy_o        <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (memReqReady_i) begin
            memReqValid_o <= 1'b0;
            beat_cnt      <= '0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (memRespValid_i) begin
            for (int unsigned k = 0; k < beatsPerLine; k++) begin
              if (beat_cnt == k[cntW-1:0]) begin
                newCacheline_o[(beatsPerLine-1-k)*memBusWidth +: memBusWidth] <= memRespData_i;
              end
            end
            beat_cnt <= beat_cnt + cntW'(1);
            if (beat_cnt == lastBeat) begin
              cacheUpdateEnable_o <= 1'b1;
              state               <= WRITE;
            end
          end
        end
        WRITE: begin
          state <= CLEAR;
        end
        CLEAR: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: every expectation below is a
// hand-computed constant for the default parameter set (tag 51, index 8,
// offset 5, 256-bit line, 64-bit beats).
module tb_icache_refill_unit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss;
  logic [50:0]  tag;
  logic [7:0]   idx;
  logic [4:0]   off;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_addr;
  logic         resp_valid;
  logic [63:0]  resp_data;
  logic [50:0]  new_tag;
  logic [7:0]   new_idx;
  logic [4:0]   new_off;
  logic [255:0] new_line;
  logic         upd;
  logic         busy;

  int checks  = 0;
  int passed  = 0;
  int strobes = 0;
  int s0;

  icache_refill_unit dut (
    .clock_i             (clk),
    .reset_i             (rst_n),
    .isCacheMiss_i       (miss),
    .missTag_i           (tag),
    .missIndex_i         (idx),
    .missOffset_i        (off),
    .memReqValid_o       (req_valid),
    .memReqReady_i       (req_ready),
    .memReqAddr_o        (req_addr),
    .memRespValid_i      (resp_valid),
    .memRespData_i       (resp_data),
    .newTag_o            (new_tag),
    .newIndex_o          (new_idx),
    .newOffset_o         (new_off),
    .newCacheline_o      (new_line),
    .cacheUpdateEnable_o (upd),
    .busy_o              (busy)
  );

  always #5 clk = ~clk;

  // Count update strobes mid-cycle, away from the active edge.
  always @(negedge clk) if (upd === 1'b1) strobes++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat presented for exactly one cycle.
  task automatic beat(input logic [63:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    tick();
    resp_valid = 1'b0;
    resp_data  = '0;
  endtask

  task automatic test_reset();
    miss = 0; tag = '0; idx = '0; off = '0;
    req_ready = 0; resp_valid = 0; resp_data = '0;
    rst_n = 0;
    tick(); tick();
    checks++;
    if ({req_valid, upd, busy} !== 3'b000)
      $display("FAIL reset_ctrl got=%b exp=000", {req_valid, upd, busy});
    else passed++;
    checks++;
    if ({req_addr, new_tag, new_idx, new_off} !== 128'd0)
      $display("FAIL reset_regs got=%h exp=0", {req_addr, new_tag, new_idx, new_off});
    else passed++;
    checks++;
    if (new_line !== 256'd0) $display("FAIL reset_line got=%h exp=0", new_line);
    else passed++;
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    s0 = strobes;
    req_ready = 1;
    miss = 1; tag = 51'h1_2345_6789_ABCD; idx = 8'h3C; off = 5'h08;
    tick();
    checks++;
    if ({req_valid, busy} !== 2'b11 || req_addr !== 64'h2468_ACF1_3579_A780)
      $display("FAIL t1_req got=%b/%h exp=11/2468acf13579a780", {req_valid, busy}, req_addr);
    else passed++;
    tick();
    checks++;
    if (req_valid !== 1'b0) $display("FAIL t1_req_drop got=%b exp=0", req_valid);
    else passed++;
    beat(64'h1111_1111_1111_1111);
    beat(64'h2222_2222_2222_2222);
    beat(64'h3333_3333_3333_3333);
    checks++;
    if (upd !== 1'b0) $display("FAIL t1_early_strobe got=%b exp=0", upd);
    else passed++;
    beat(64'h4444_4444_4444_4444);
    checks++;
    if (upd !== 1'b1) $display("FAIL t1_strobe got=%b exp=1", upd);
    else passed++;
    checks++;
    if (new_line !== 256'h1111111111111111_2222222222222222_3333333333333333_4444444444444444)
      $display("FAIL t1_line got=%h", new_line);
    else passed++;
    checks++;
    if (new_tag !== 51'h1_2345_6789_ABCD || new_idx !== 8'h3C || new_off !== 5'h08)
      $display("FAIL t1_meta got=%h/%h/%h exp=123456789abcd/3c/08", new_tag, new_idx, new_off);
    else passed++;
    miss = 0;
    tick();
    checks++;
    if ({upd, busy} !== 2'b01) $display("FAIL t1_clear got=%b exp=01", {upd, busy});
    else passed++;
    tick();
    checks++;
    if (busy !== 1'b0 || strobes - s0 !== 1)
      $display("FAIL t1_done busy=%b strobes=%0d exp=0/1", busy, strobes - s0);
    else passed++;
    checks++;
    if (new_off !== 5'h08 || new_tag !== 51'h1_2345_6789_ABCD)
      $display("FAIL t1_hold got=%h/%h exp=08/123456789abcd", new_off, new_tag);
    else passed++;
  endtask

  task automatic test_stall();
    s0 = strobes;
    req_ready = 0;
    miss = 1; tag = 51'h1; idx = 8'hFF; off = 5'h1F;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (req_valid !== 1'b1 || req_addr !== 64'h0000_0000_0000_3FE0)
        $display("FAIL t2_stall%0d got=%b/%h exp=1/3fe0", i, req_valid, req_addr);
      else passed++;
      req_ready  = (i == 5);
      resp_valid = (i != 5);
      resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
    end
    resp_valid = 0;
    resp_data  = '0;
    req_ready  = 1;
    checks++;
    if (req_valid !== 1'b0) $display("FAIL t2_req_drop got=%b exp=0", req_valid);
    else passed++;
    beat(64'hA0A0_A0A0_A0A0_A0A0);
    beat(64'hB1B1_B1B1_B1B1_B1B1);
    beat(64'hC2C2_C2C2_C2C2_C2C2);
    checks++;
    if (upd !== 1'b0) $display("FAIL t2_no_early got=%b exp=0", upd);
    else passed++;
    beat(64'hD3D3_D3D3_D3D3_D3D3);
    checks++;
    if (upd !== 1'b1 || new_line !== 256'hA0A0A0A0A0A0A0A0_B1B1B1B1B1B1B1B1_C2C2C2C2C2C2C2C2_D3D3D3D3D3D3D3D3)
      $display("FAIL t2_line strobe=%b got=%h", upd, new_line);
    else passed++;
    miss = 0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || strobes - s0 !== 1)
      $display("FAIL t2_done busy=%b strobes=%0d exp=0/1", busy, strobes - s0);
    else passed++;
  endtask

  task automatic test_gaps();
    logic [63:0] d [4];
    d[0] = 64'h0102_0304_0506_0708;
    d[1] = 64'h1112_1314_1516_1718;
    d[2] = 64'h2122_2324_2526_2728;
    d[3] = 64'h3132_3334_3536_3738;
    s0 = strobes;
    beat(64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    checks++;
    if (busy !== 1'b0 || new_line !== 256'hA0A0A0A0A0A0A0A0_B1B1B1B1B1B1B1B1_C2C2C2C2C2C2C2C2_D3D3D3D3D3D3D3D3)
      $display("FAIL t3_spurious busy=%b line=%h", busy, new_line);
    else passed++;
    req_ready = 1;
    miss = 1; tag = 51'h5; idx = 8'h01; off = 5'h02;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      beat(d[k]);
      if (k < 3) begin
        tick(); tick();
        checks++;
        if (upd !== 1'b0 || busy !== 1'b1)
          $display("FAIL t3_gap%0d strobe=%b busy=%b exp=0/1", k, upd, busy);
        else passed++;
      end
    end
    checks++;
    if (upd !== 1'b1 || new_line !== 256'h0102030405060708_1112131415161718_2122232425262728_3132333435363738)
      $display("FAIL t3_line strobe=%b got=%h", upd, new_line);
    else passed++;
    miss = 0;
    tick(); tick();
    checks++;
    if (strobes - s0 !== 1) $display("FAIL t3_strobes got=%0d exp=1", strobes - s0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    s0 = strobes;
    req_ready = 1;
    miss = 1; tag = 51'hAA; idx = 8'h55; off = 5'h03;
    tick();
    checks++;
    if (req_addr !== 64'h0000_0000_0015_4AA0) $display("FAIL t4_addr_a got=%h exp=154aa0", req_addr);
    else passed++;
    tick();
    for (int k = 0; k < 4; k++) beat(64'hAAAA_0000_0000_0000 + 64'(k));
    checks++;
    if (upd !== 1'b1 || new_tag !== 51'hAA || new_idx !== 8'h55)
      $display("FAIL t4_first strobe=%b tag=%h idx=%h exp=1/aa/55", upd, new_tag, new_idx);
    else passed++;
    miss = 0;
    tick();
    miss = 1; tag = 51'h7_FFFF_FFFF_FFFF; idx = 8'h00; off = 5'h00;
    checks++;
    if ({req_valid, busy} !== 2'b01) $display("FAIL t4_clear got=%b exp=01", {req_valid, busy});
    else passed++;
    tick();
    checks++;
    if ({req_valid, busy} !== 2'b00) $display("FAIL t4_idle got=%b exp=00", {req_valid, busy});
    else passed++;
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 64'hFFFF_FFFF_FFFF_E000)
      $display("FAIL t4_addr_b got=%b/%h exp=1/ffffffffffffe000", req_valid, req_addr);
    else passed++;
    tick();
    for (int k = 0; k < 4; k++) beat(64'hBBBB_0000_0000_0000 + 64'(k));
    checks++;
    if (upd !== 1'b1 || new_tag !== 51'h7_FFFF_FFFF_FFFF || new_idx !== 8'h00 ||
        new_line !== 256'hBBBB000000000000_BBBB000000000001_BBBB000000000002_BBBB000000000003)
      $display("FAIL t4_second strobe=%b tag=%h idx=%h line=%h", upd, new_tag, new_idx, new_line);
    else passed++;
    miss = 0;
    tick(); tick();
    checks++;
    if (strobes - s0 !== 2) $display("FAIL t4_strobes got=%0d exp=2", strobes - s0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    s0 = strobes;
    req_ready = 1;
    miss = 1; tag = 51'h99; idx = 8'h77; off = 5'h04;
    tick(); tick();
    beat(64'h5555_5555_5555_5555);
    beat(64'h6666_6666_6666_6666);
    rst_n = 0;
    miss = 0;
    resp_valid = 1; resp_data = 64'h7777_7777_7777_7777;
    #1;
    checks++;
    if ({busy, req_valid, upd} !== 3'b000 || {req_addr, new_tag, new_idx, new_off} !== 128'd0 ||
        new_line !== 256'd0)
      $display("FAIL t5_async busy=%b addr=%h tag=%h line=%h exp=0", busy, req_addr, new_tag, new_line);
    else passed++;
    tick();
    rst_n = 1;
    resp_data = 64'h8888_8888_8888_8888;
    tick(); tick();
    resp_valid = 0; resp_data = '0;
    tick();
    checks++;
    if (busy !== 1'b0 || new_line !== 256'd0 || strobes - s0 !== 0)
      $display("FAIL t5_dropped busy=%b strobes=%0d line=%h", busy, strobes - s0, new_line);
    else passed++;
    miss = 1; tag = 51'h2A; idx = 8'h0F; off = 5'h10;
    tick();
    checks++;
    if (req_addr !== 64'h0000_0000_0005_41E0) $display("FAIL t5_addr got=%h exp=541e0", req_addr);
    else passed++;
    tick();
    beat(64'h0000_0000_0000_00C0);
    beat(64'h0000_0000_0000_00C1);
    beat(64'h0000_0000_0000_00C2);
    beat(64'h0000_0000_0000_00C3);
    checks++;
    if (upd !== 1'b1 || new_off !== 5'h10 ||
        new_line !== 256'h00000000000000C0_00000000000000C1_00000000000000C2_00000000000000C3)
      $display("FAIL t5_refill strobe=%b off=%h line=%h", upd, new_off, new_line);
    else passed++;
    miss = 0;
    tick(); tick();
  endtask

  task automatic test_held_miss();
    s0 = strobes;
    req_ready = 1;
    miss = 1; tag = 51'h3; idx = 8'h33; off = 5'h0C;
    tick(); tick();
    for (int k = 0; k < 4; k++) beat(64'hE0E0_0000_0000_0000 + 64'(k));
    checks++;
    if (upd !== 1'b1) $display("FAIL t6_strobe got=%b exp=1", upd);
    else passed++;
    tick();
    miss = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({busy, req_valid} !== 2'b00) $display("FAIL t6_idle%0d got=%b exp=00", i, {busy, req_valid});
      else passed++;
    end
    checks++;
    if (strobes - s0 !== 1) $display("FAIL t6_strobes got=%0d exp=1", strobes - s0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_held_miss();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
